// File: rtl/sparc_exu_ccr_lwb_if.sv
// Long-latency cc writeback bundle between EXU producers and the CCR.
// slave = writeback queue side, master = producer/consumer side.
interface sparc_exu_ccr_lwb_if;
  logic       div_ccr_vld;
  logic [1:0] div_ccr_tid;
  logic [7:0] div_ccr_cc;
  logic       mul_ccr_vld;
  logic [1:0] mul_ccr_tid;
  logic [7:0] mul_ccr_cc;
  logic       ecl_lwb_stall;
  logic       wb_ccr_setcc_g;
  logic [1:0] wb_ccr_thr_g;
  logic [7:0] divcntl_ccr_cc_w2;
  logic [3:0] lwb_pend;
  logic       lwb_ovf;

  modport slave (
    input  div_ccr_vld, div_ccr_tid, div_ccr_cc,
    input  mul_ccr_vld, mul_ccr_tid, mul_ccr_cc,
    input  ecl_lwb_stall,
    output wb_ccr_setcc_g, wb_ccr_thr_g,
    output divcntl_ccr_cc_w2, lwb_pend, lwb_ovf
  );

  modport master (
    output div_ccr_vld, div_ccr_tid, div_ccr_cc,
    output mul_ccr_vld, mul_ccr_tid, mul_ccr_cc,
    output ecl_lwb_stall,
    input  wb_ccr_setcc_g, wb_ccr_thr_g,
    input  divcntl_ccr_cc_w2, lwb_pend, lwb_ovf
  );
endinterface

// File: rtl/sparc_exu_ccr_lwb.sv
// Per-thread pending queue for divider/multiplier cc results,
// drained round-robin onto the CCR long-latency write port.
module sparc_exu_ccr_lwb #(
  parameter int NTHR = 4,
  parameter int CCW  = 8
) (
  input  logic                clk,
  input  logic                reset,
  sparc_exu_ccr_lwb_if.slave  lwb
);

  logic [NTHR-1:0] pend_q, pend_d;
  logic [CCW-1:0]  cc_q [NTHR];
  logic [CCW-1:0]  cc_d [NTHR];
  logic [1:0]      lg_q, lg_d;
  logic [CCW-1:0]  cc_w2_q, cc_w2_d;
  logic            ovf_q, ovf_d;

  logic [1:0]      thr;
  logic            found;
  logic            issue;
  logic [1:0]      idx;
  logic            same_tid;

  // First pending thread after the last grant; lg+1 when idle.
  always_comb begin
    thr   = lg_q + 2'd1;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 1; k <= NTHR; k++) begin
      idx = lg_q + 2'(k);
      if (!found && pend_q[idx]) begin
        thr   = idx;
        found = 1'b1;
      end
    end
  end

  assign issue    = (|pend_q) & ~lwb.ecl_lwb_stall;
  assign same_tid = lwb.div_ccr_vld & lwb.mul_ccr_vld &
                    (lwb.div_ccr_tid == lwb.mul_ccr_tid);

  always_comb begin
    pend_d  = pend_q;
    cc_d    = cc_q;
    ovf_d   = ovf_q;
    lg_d    = lg_q;
    cc_w2_d = cc_w2_q;

    if (issue) begin
      pend_d[thr] = 1'b0;
      lg_d        = thr;
      cc_w2_d     = cc_q[thr];
    end

    // Recapture into the slot being drained is a clean refill.
    if (lwb.mul_ccr_vld && !same_tid) begin
      cc_d[lwb.mul_ccr_tid]   = lwb.mul_ccr_cc;
      pend_d[lwb.mul_ccr_tid] = 1'b1;
      if (pend_q[lwb.mul_ccr_tid] &&
          !(issue && thr == lwb.mul_ccr_tid))
        ovf_d = 1'b1;
    end

    if (lwb.div_ccr_vld) begin
      cc_d[lwb.div_ccr_tid]   = lwb.div_ccr_cc;
      pend_d[lwb.div_ccr_tid] = 1'b1;
      if (pend_q[lwb.div_ccr_tid] &&
          !(issue && thr == lwb.div_ccr_tid))
        ovf_d = 1'b1;
    end

    if (same_tid)
      ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q  <= '0;
      lg_q    <= 2'd3;
      cc_w2_q <= '0;
      ovf_q   <= 1'b0;
      for (int t = 0; t < NTHR; t++)
        cc_q[t] <= '0;
    end else begin
      pend_q  <= pend_d;
      lg_q    <= lg_d;
      cc_w2_q <= cc_w2_d;
      ovf_q   <= ovf_d;
      for (int t = 0; t < NTHR; t++)
        cc_q[t] <= cc_d[t];
    end
  end

  assign lwb.wb_ccr_setcc_g    = issue;
  assign lwb.wb_ccr_thr_g      = thr;
  assign lwb.divcntl_ccr_cc_w2 = cc_w2_q;
  assign lwb.lwb_pend          = pend_q;
  assign lwb.lwb_ovf           = ovf_q;

endmodule

// File: tb/tb_sparc_exu_ccr_lwb.sv
// Directed bench for the long-latency cc writeback queue.
// Inputs change at negedge; outputs are checked at negedge before the change.
module tb_sparc_exu_ccr_lwb;

  logic clk;
  logic reset;
  int   nvec;
  int   nerr;

  sparc_exu_ccr_lwb_if bus ();

  sparc_exu_ccr_lwb dut (
    .clk   (clk),
    .reset (reset),
    .lwb   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag,
                      input logic       s,
                      input logic [1:0] t,
                      input logic [7:0] w2,
                      input logic [3:0] p,
                      input logic       o);
    chk({tag, ".setcc"}, {7'd0, bus.wb_ccr_setcc_g}, {7'd0, s});
    chk({tag, ".thr"},   {6'd0, bus.wb_ccr_thr_g},   {6'd0, t});
    chk({tag, ".cc_w2"}, bus.divcntl_ccr_cc_w2,      w2);
    chk({tag, ".pend"},  {4'd0, bus.lwb_pend},       {4'd0, p});
    chk({tag, ".ovf"},   {7'd0, bus.lwb_ovf},        {7'd0, o});
  endtask

  task automatic idle();
    bus.div_ccr_vld = 1'b0;
    bus.mul_ccr_vld = 1'b0;
  endtask

  task automatic div(input logic [1:0] t, input logic [7:0] c);
    bus.div_ccr_vld = 1'b1;
    bus.div_ccr_tid = t;
    bus.div_ccr_cc  = c;
  endtask

  task automatic mul(input logic [1:0] t, input logic [7:0] c);
    bus.mul_ccr_vld = 1'b1;
    bus.mul_ccr_tid = t;
    bus.mul_ccr_cc  = c;
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    reset = 1'b1;
    bus.div_ccr_vld   = 1'b0;
    bus.div_ccr_tid   = 2'd0;
    bus.div_ccr_cc    = 8'h00;
    bus.mul_ccr_vld   = 1'b0;
    bus.mul_ccr_tid   = 2'd0;
    bus.mul_ccr_cc    = 8'h00;
    bus.ecl_lwb_stall = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // single capture, tid 2
    @(negedge clk);
    outs("rst", 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0);
    div(2'd2, 8'hA5);
    @(negedge clk);
    outs("s1a", 1'b1, 2'd2, 8'h00, 4'b0100, 1'b0);
    idle();
    @(negedge clk);
    outs("s1b", 1'b0, 2'd3, 8'hA5, 4'b0000, 1'b0);

    // tids 0,1,3 on consecutive cycles
    div(2'd0, 8'h01);
    @(negedge clk);
    outs("s2a", 1'b1, 2'd0, 8'hA5, 4'b0001, 1'b0);
    idle();
    mul(2'd1, 8'h12);
    @(negedge clk);
    outs("s2b", 1'b1, 2'd1, 8'h01, 4'b0010, 1'b0);
    idle();
    div(2'd3, 8'h33);
    @(negedge clk);
    outs("s2c", 1'b1, 2'd3, 8'h12, 4'b1000, 1'b0);
    idle();
    @(negedge clk);
    outs("s2d", 1'b0, 2'd0, 8'h33, 4'b0000, 1'b0);

    // build all-four pending with lg=1, then drain with a stall
    div(2'd1, 8'h10);
    @(negedge clk);
    outs("s3a", 1'b1, 2'd1, 8'h33, 4'b0010, 1'b0);
    div(2'd0, 8'hA0);
    mul(2'd2, 8'hC2);
    @(negedge clk);
    outs("s3b", 1'b1, 2'd2, 8'h10, 4'b0101, 1'b0);
    idle();
    bus.ecl_lwb_stall = 1'b1;
    div(2'd3, 8'hD3);
    @(negedge clk);
    outs("s3c", 1'b0, 2'd2, 8'h10, 4'b1101, 1'b0);
    div(2'd1, 8'hB1);
    @(negedge clk);
    outs("s3d", 1'b0, 2'd2, 8'h10, 4'b1111, 1'b0);
    idle();
    bus.ecl_lwb_stall = 1'b0;
    @(negedge clk);
    outs("s3e", 1'b1, 2'd3, 8'hC2, 4'b1011, 1'b0);
    bus.ecl_lwb_stall = 1'b1;
    @(negedge clk);
    outs("s3f", 1'b0, 2'd3, 8'hC2, 4'b1011, 1'b0);
    @(negedge clk);
    outs("s3g", 1'b0, 2'd3, 8'hC2, 4'b1011, 1'b0);
    bus.ecl_lwb_stall = 1'b0;
    @(negedge clk);
    outs("s3h", 1'b1, 2'd0, 8'hD3, 4'b0011, 1'b0);
    @(negedge clk);
    outs("s3i", 1'b1, 2'd1, 8'hA0, 4'b0010, 1'b0);
    @(negedge clk);
    outs("s3j", 1'b0, 2'd2, 8'hB1, 4'b0000, 1'b0);

    // same-tid collision, div wins
    div(2'd1, 8'h11);
    mul(2'd1, 8'h22);
    @(negedge clk);
    outs("s4a", 1'b1, 2'd1, 8'hB1, 4'b0010, 1'b1);
    idle();
    @(negedge clk);
    outs("s4b", 1'b0, 2'd2, 8'h11, 4'b0000, 1'b1);
    @(negedge clk);
    outs("s4c", 1'b0, 2'd2, 8'h11, 4'b0000, 1'b1);

    // recapture into slot being issued
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    outs("s5r", 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0);
    div(2'd0, 8'h0F);
    @(negedge clk);
    outs("s5a", 1'b1, 2'd0, 8'h00, 4'b0001, 1'b0);
    idle();
    mul(2'd0, 8'hF0);
    @(negedge clk);
    outs("s5b", 1'b1, 2'd0, 8'h0F, 4'b0001, 1'b0);
    idle();
    @(negedge clk);
    outs("s5c", 1'b0, 2'd1, 8'hF0, 4'b0000, 1'b0);

    // overwrite of a parked slot, then async reset with 3 pending
    bus.ecl_lwb_stall = 1'b1;
    div(2'd0, 8'h40);
    mul(2'd1, 8'h41);
    @(negedge clk);
    idle();
    div(2'd2, 8'h42);
    @(negedge clk);
    idle();
    div(2'd0, 8'h44);
    @(negedge clk);
    outs("s6a", 1'b0, 2'd1, 8'hF0, 4'b0111, 1'b1);
    idle();
    #2;
    reset = 1'b1;
    #1;
    outs("s6r", 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0);
    #1;
    reset = 1'b0;
    bus.ecl_lwb_stall = 1'b0;
    @(negedge clk);
    outs("s6b", 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0);
    @(negedge clk);
    outs("s6c", 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/sparc_exu_ccr_lwb.md
Name: sparc_exu_ccr_lwb

Overview:
- Long-latency condition-code writeback queue for the EXU ECL.
- Captures icc/xcc results from the divider and multiplier when they complete, out of the normal pipeline.
- Holds them in per-thread pending slots and issues one write per cycle, round-robin, on the CCR long-latency write port: setcc/thread at G, cc data at W2.
- Feeds wb_ccr_setcc_g, wb_ccr_thr_g and divcntl_ccr_cc_w2 of the CCR storage block. Reports per-thread pending status to thread-switch logic.

Parameters:
NTHR, 4, number of hardware threads (fixed at 4; tid is 2 bits)
CCW, 8, condition-code width ({xcc[3:0], icc[3:0]})

Ports:
clk  input  1  core clock; all flops rising edge
reset  input  1  asynchronous, active-high reset
div_ccr_vld  input  1  divider completion with cc update this cycle
div_ccr_tid  input  2  thread of divider result
div_ccr_cc  input  8  divider {xcc,icc}
mul_ccr_vld  input  1  multiplier completion with cc update this cycle
mul_ccr_tid  input  2  thread of multiplier result
mul_ccr_cc  input  8  multiplier {xcc,icc}
ecl_lwb_stall  input  1  block issue this cycle (pending slots retained)
wb_ccr_setcc_g  output  1  long-latency cc write request, G stage
wb_ccr_thr_g  output  2  thread of the G-stage request
divcntl_ccr_cc_w2  output  8  cc data, valid the cycle after wb_ccr_setcc_g
lwb_pend  output  4  per-thread slot occupied (decoded)
lwb_ovf  output  1  sticky: capture into an already-occupied slot

Behaviour:
- State per thread t: pend[t], cc[t][7:0]. Also: last-grant pointer lg[1:0], registered cc_w2[7:0], sticky ovf.
- Reset values (async): pend=0, cc=0, lg=3 (thread 0 wins first), cc_w2=0, ovf=0.
  - Hence setcc_g=0, thr_g=0, cc_w2=0, lwb_pend=0, lwb_ovf=0.
- Capture (cycle N):
  - div_ccr_vld writes cc[div_ccr_tid] and sets pend.
  - mul_ccr_vld does the same for mul_ccr_tid.
  - Different tids in the same cycle: both captured.
  - Same tid in the same cycle: div data written, ovf set.
  - Capture into a slot that is pend=1 and not being issued this cycle: data overwritten, ovf set.
  - Capture into the slot being issued this cycle: the new data is kept, pend stays 1, no ovf. The issued W2 data is the old value.
- Issue:
  - wb_ccr_setcc_g = |pend & ~ecl_lwb_stall. This is combinational from flops plus stall; there is no same-cycle bypass from capture, so earliest issue is N+1.
  - wb_ccr_thr_g = the first pending thread searching lg+1, lg+2, lg+3, lg (mod 4). When nothing is pending, it equals lg+1.
  - On the issue edge: pend[thr_g] cleared (unless recaptured), lg <= thr_g, cc_w2 <= cc[thr_g].
  - divcntl_ccr_cc_w2 is driven from cc_w2. It holds its value until the next issue.
- Stall: no pend clear, lg and cc_w2 unchanged, captures still accepted.
- lwb_pend = pend (registered). The IFU keeps a thread parked until its bit drops.
- Throughput: 1 write/cycle. Max G latency from capture for any thread with no stall is 4 cycles.
- Reset asserted mid-operation: all pending writes are discarded and outputs go to reset values immediately.

Test Plan:
- Reset, then div_ccr_vld tid=2 cc=8'hA5 at N -> setcc_g=1 thr_g=2 at N+1, cc_w2=8'hA5 at N+2, lwb_pend=4'b0100 at N+1 only, ovf=0.
- Capture tids 0,1,3 (div, mul, div over consecutive cycles), each with distinct cc -> issues in order 0,1,3 at one per cycle; each cc_w2 matches its thread one cycle after its setcc_g.
- All four slots pending with lg=1 -> grant order 2,3,0,1. Stall asserted for 2 cycles mid-sequence -> setcc_g=0, order and data preserved afterwards.
- div and mul both valid with tid=1, cc 8'h11 / 8'h22 -> slot holds 8'h11, lwb_ovf=1 and stays 1 until reset.
- Slot 0 issuing with old cc 8'h0F while mul tid=0 cc 8'hF0 arrives -> cc_w2=8'h0F; next cycle setcc_g=1 thr_g=0; following cycle cc_w2=8'hF0; ovf=0.
- reset pulsed while 3 slots are pending -> lwb_pend=0, setcc_g=0, cc_w2=0 asynchronously; no issue after release.
